// File: rtl/audio_gain_fifo.sv
// Multi-channel volume stage: three-stage gain/saturate pipeline feeding a
// first-word-fall-through output FIFO with occupancy counter and sticky overflow.
module audio_gain_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int VOL_WIDTH  = 32,
    parameter int VOL_SHIFT  = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           in_wr_en,
    output logic                           in_full,
    input  logic [VOL_WIDTH-1:0]           volume,
    input  logic                           mute,
    input  logic                           out_rd_en,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_empty,
    output logic [$clog2(FIFO_DEPTH):0]    out_count,
    output logic                           overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = CHANNELS * DATA_WIDTH;
    localparam int PW = DATA_WIDTH + VOL_WIDTH + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic                             s1_valid_r, s2_valid_r, s3_valid_r;
    logic [WW-1:0]                    s1_data_r;
    logic [VOL_WIDTH-1:0]             s1_vol_r;
    logic                             s1_mute_r, s2_mute_r;
    logic [CHANNELS-1:0][PW-1:0]      prod_s, s2_prod_r;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] res_s;
    logic [WW-1:0]                    s3_data_r;

    logic [WW-1:0]                    mem_r [FIFO_DEPTH];
    logic [AW-1:0]                    wr_ptr_r, rd_ptr_r, rd_ptr_inc_s;
    logic [CW-1:0]                    count_r, count_next_s;
    logic [CW:0]                      occupancy_s;
    logic [WW-1:0]                    head_r, head_next_s;
    logic                             empty_r, overflow_r;
    logic                             full_s, accept_s, push_s, pop_s;

    // In-flight stages count against capacity, so a stage-3 write always has room.
    assign occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, s1_valid_r}
                       + {{CW{1'b0}}, s2_valid_r} + {{CW{1'b0}}, s3_valid_r};
    assign full_s       = (occupancy_s >= (CW+1)'(FIFO_DEPTH));
    assign accept_s     = in_wr_en && !full_s;
    assign push_s       = s3_valid_r;
    assign pop_s        = out_rd_en && !empty_r;
    assign rd_ptr_inc_s = rd_ptr_r + PTR_ONE;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] smp_s;
        logic [PW-1:0]         smp_ext_s, vol_ext_s, shifted_s;
        logic                  in_range_s;

        assign smp_s      = s1_data_r[k*DATA_WIDTH +: DATA_WIDTH];
        assign smp_ext_s  = {{(VOL_WIDTH+1){smp_s[DATA_WIDTH-1]}}, smp_s};
        assign vol_ext_s  = {{(DATA_WIDTH+1){1'b0}}, s1_vol_r};
        assign prod_s[k]  = smp_ext_s * vol_ext_s;
        assign shifted_s  = $signed(s2_prod_r[k]) >>> VOL_SHIFT;
        // Result fits when every bit above the sample's sign bit matches it.
        assign in_range_s = (&shifted_s[PW-1:DATA_WIDTH-1]) || !(|shifted_s[PW-1:DATA_WIDTH-1]);

        // Stage-3 mute / pass / saturate selection for this channel.
        always_comb begin
            res_s[k] = {DATA_WIDTH{1'b0}};
            if (s2_mute_r) begin
                res_s[k] = {DATA_WIDTH{1'b0}};
            end else if (in_range_s) begin
                res_s[k] = shifted_s[DATA_WIDTH-1:0];
            end else if (shifted_s[PW-1]) begin
                res_s[k] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                res_s[k] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
    end

    // Next occupancy and next FIFO head, so the head output can be registered.
    always_comb begin
        count_next_s = count_r;
        head_next_s  = head_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {WW{1'b0}};
        end else if (pop_s) begin
            if (count_r == CNT_ONE) begin
                head_next_s = s3_data_r;
            end else begin
                head_next_s = mem_r[rd_ptr_inc_s];
            end
        end else if (count_r == {CW{1'b0}}) begin
            head_next_s = s3_data_r;
        end else begin
            head_next_s = head_r;
        end
    end

    // Control state: pipeline valids, pointers, occupancy, head and overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            head_r     <= {WW{1'b0}};
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            s2_valid_r <= s1_valid_r;
            s3_valid_r <= s2_valid_r;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_inc_s;
            count_r    <= count_next_s;
            head_r     <= head_next_s;
            empty_r    <= (count_next_s == {CW{1'b0}});
            overflow_r <= overflow_r || (in_wr_en && full_s);
        end
    end

    // Datapath registers and FIFO storage; contents are qualified by the valids.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            s1_data_r <= in_data;
            s1_vol_r  <= volume;
            s1_mute_r <= mute;
        end
        s2_prod_r <= prod_s;
        s2_mute_r <= s1_mute_r;
        s3_data_r <= res_s;
        if (push_s) mem_r[wr_ptr_r] <= s3_data_r;
    end

    assign in_full   = full_s;
    assign out_data  = head_r;
    assign out_empty = empty_r;
    assign out_count = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_audio_gain_fifo.sv
// Directed bench for audio_gain_fifo: stereo 32-bit instance plus a 4-channel
// 16-bit depth-4 instance, with hand-computed expected results.
module tb_audio_gain_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = 64'd0;
    logic        in_wr_en = 1'b0, in_full;
    logic [31:0] volume = 32'd1024;
    logic        mute = 1'b0, out_rd_en = 1'b0;
    logic [63:0] out_data;
    logic        out_empty, overflow;
    logic [4:0]  out_count;

    logic [63:0] in_data4 = 64'd0;
    logic        in_wr_en4 = 1'b0, in_full4;
    logic [31:0] volume4 = 32'd10;
    logic        mute4 = 1'b0, out_rd_en4 = 1'b0;
    logic [63:0] out_data4;
    logic        out_empty4, overflow4;
    logic [2:0]  out_count4;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] din;
        logic [31:0] vol;
        logic        mte;
        logic [63:0] dout;
    } vec_t;
    vec_t vecs[10];

    audio_gain_fifo u_dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_wr_en(in_wr_en),
        .in_full(in_full), .volume(volume), .mute(mute), .out_rd_en(out_rd_en),
        .out_data(out_data), .out_empty(out_empty), .out_count(out_count),
        .overflow(overflow)
    );

    audio_gain_fifo #(.DATA_WIDTH(16), .CHANNELS(4), .VOL_WIDTH(32),
                      .VOL_SHIFT(10), .FIFO_DEPTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .in_data(in_data4), .in_wr_en(in_wr_en4),
        .in_full(in_full4), .volume(volume4), .mute(mute4), .out_rd_en(out_rd_en4),
        .out_data(out_data4), .out_empty(out_empty4), .out_count(out_count4),
        .overflow(overflow4)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int n);
        return {32'(n * 3 + 7), 32'(n)};
    endfunction

    // Push/pop every cycle once occupancy reaches target; order and count must hold.
    task automatic stream(input int target, input int total, input int base);
        int  sent    = 0;
        int  rd      = 0;
        bit  reading = 1'b0;
        volume = 32'd1024;
        mute   = 1'b0;
        for (int cyc = 0; cyc < total + 40 && rd < total; cyc++) begin
            in_wr_en = (sent < total);
            in_data  = mk(base + sent);
            if (!reading && (32'(out_count) == target)) reading = 1'b1;
            out_rd_en = reading;
            if (reading) chk($sformatf("stream%0d_data%0d", target, rd), out_data, mk(base + rd));
            tick();
            if (in_wr_en) sent++;
            if (reading) begin
                rd++;
                if (sent < total) begin
                    chk($sformatf("stream%0d_count", target), 64'(out_count), 64'(target));
                    chk($sformatf("stream%0d_ovf", target), 64'(overflow), 64'd0);
                end
            end
        end
        in_wr_en  = 1'b0;
        out_rd_en = 1'b0;
        chk($sformatf("stream%0d_done", target), 64'(rd), 64'(total));
        chk($sformatf("stream%0d_empty", target), 64'(out_empty), 64'd1);
    endtask

    initial begin
        vecs[0] = '{64'hFFFFF000_00001000, 32'd1024,       1'b0, 64'hFFFFF000_00001000};
        vecs[1] = '{64'hC0000000_40000000, 32'd4096,       1'b0, 64'h80000000_7FFFFFFF};
        vecs[2] = '{64'hC0000000_40000000, 32'd4096,       1'b1, 64'h00000000_00000000};
        vecs[3] = '{64'hFFFFF000_00001000, 32'd10,         1'b0, 64'hFFFFFFD8_00000028};
        vecs[4] = '{64'h00000001_FFFFFFFF, 32'd10,         1'b0, 64'h00000000_FFFFFFFF};
        vecs[5] = '{64'h12345678_9ABCDEF0, 32'd0,          1'b0, 64'h00000000_00000000};
        vecs[6] = '{64'h00000003_FFFFFFFD, 32'd512,        1'b0, 64'h00000001_FFFFFFFE};
        vecs[7] = '{64'h00000000_00000001, 32'hFFFFFFFF,   1'b0, 64'h00000000_003FFFFF};
        vecs[8] = '{64'h00000010_7FFFFFFF, 32'd2048,       1'b0, 64'h00000020_7FFFFFFF};
        vecs[9] = '{64'h80000000_80000000, 32'd1024,       1'b0, 64'h80000000_80000000};

        tick();
        tick();
        chk("rst_full",     64'(in_full),   64'd0);
        chk("rst_empty",    64'(out_empty), 64'd1);
        chk("rst_count",    64'(out_count), 64'd0);
        chk("rst_overflow", 64'(overflow),  64'd0);
        chk("rst_data",     out_data,       64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            in_data  = vecs[i].din;
            volume   = vecs[i].vol;
            mute     = vecs[i].mte;
            in_wr_en = 1'b1;
            tick();
            in_wr_en = 1'b0;
            tick();
            tick();
            chk($sformatf("vec%0d_latency", i), 64'(out_empty), 64'd1);
            tick();
            chk($sformatf("vec%0d_data", i),  out_data,       vecs[i].dout);
            chk($sformatf("vec%0d_count", i), 64'(out_count), 64'd1);
            chk($sformatf("vec%0d_empty", i), 64'(out_empty), 64'd0);
            out_rd_en = 1'b1;
            tick();
            out_rd_en = 1'b0;
            chk($sformatf("vec%0d_pop_empty", i), 64'(out_empty), 64'd1);
            chk($sformatf("vec%0d_pop_data", i),  out_data,       64'd0);
        end
        mute = 1'b0;

        // Four 16-bit channels, volume 10: floor shift turns -1 into -1 and 1 into 0.
        in_data4  = {16'h0001, 16'hFFFF, 16'hF000, 16'h1000};
        in_wr_en4 = 1'b1;
        tick();
        in_wr_en4 = 1'b0;
        tick(); tick(); tick();
        chk("ch4_data",  out_data4,       {16'h0000, 16'hFFFF, 16'hFFD8, 16'h0028});
        chk("ch4_count", 64'(out_count4), 64'd1);
        out_rd_en4 = 1'b1;
        tick();
        out_rd_en4 = 1'b0;
        chk("ch4_pop_empty", 64'(out_empty4), 64'd1);

        // Gain and mute changes take effect only for later samples.
        in_data  = {32'h0, 32'h100};
        volume   = 32'd4096;
        in_wr_en = 1'b1;
        tick();
        volume = 32'd1024;
        tick();
        mute = 1'b1;
        tick();
        in_wr_en = 1'b0;
        mute     = 1'b0;
        tick(); tick(); tick();
        chk("gchg_count", 64'(out_count), 64'd3);
        chk("gchg_a", out_data, 64'h00000000_00000400);
        out_rd_en = 1'b1;
        tick();
        chk("gchg_b", out_data, 64'h00000000_00000100);
        tick();
        chk("gchg_c", out_data, 64'd0);
        chk("gchg_c_empty", 64'(out_empty), 64'd0);
        tick();
        out_rd_en = 1'b0;
        chk("gchg_end_empty", 64'(out_empty), 64'd1);

        // 20 back-to-back writes into a 16-deep FIFO: last 4 refused.
        for (int i = 0; i < 20; i++) begin
            in_data  = mk(i);
            in_wr_en = 1'b1;
            tick();
            if (i == 14) chk("full_before", 64'(in_full), 64'd0);
            if (i == 15) chk("full_after16", 64'(in_full), 64'd1);
            if (i == 15) chk("ovf_before", 64'(overflow), 64'd0);
            if (i == 16) chk("ovf_after", 64'(overflow), 64'd1);
        end
        in_wr_en = 1'b0;
        tick(); tick(); tick();
        chk("full_count", 64'(out_count), 64'd16);
        chk("full_flag",  64'(in_full),   64'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_pop%0d", i), out_data, mk(i));
            out_rd_en = 1'b1;
            tick();
            if (i == 0) chk("full_release", 64'(in_full), 64'd0);
        end
        out_rd_en = 1'b0;
        chk("full_drained_empty", 64'(out_empty), 64'd1);
        chk("full_drained_data",  out_data,       64'd0);
        chk("full_drained_count", 64'(out_count), 64'd0);
        chk("ovf_sticky",         64'(overflow),  64'd1);

        // Reset with 5 buffered and 2 in flight.
        for (int i = 0; i < 7; i++) begin
            in_data  = mk(200 + i);
            in_wr_en = 1'b1;
            tick();
        end
        in_wr_en = 1'b0;
        tick();
        chk("mrst_pre_count", 64'(out_count), 64'd5);
        reset = 1'b1;
        tick();
        chk("mrst_empty", 64'(out_empty), 64'd1);
        chk("mrst_count", 64'(out_count), 64'd0);
        chk("mrst_ovf",   64'(overflow),  64'd0);
        chk("mrst_full",  64'(in_full),   64'd0);
        chk("mrst_data",  out_data,       64'd0);
        reset = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("mrst_no_stale_empty", 64'(out_empty), 64'd1);
        chk("mrst_no_stale_count", 64'(out_count), 64'd0);

        // Pop while empty is ignored; the next sample must still come out cleanly.
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
        chk("epop_count", 64'(out_count), 64'd0);
        in_data  = mk(300);
        in_wr_en = 1'b1;
        tick();
        in_wr_en = 1'b0;
        tick(); tick(); tick();
        chk("epop_data",  out_data,       mk(300));
        chk("epop_count1", 64'(out_count), 64'd1);
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;

        stream(1, 40, 400);
        stream(12, 40, 500);

        // Full with a stage-3 write pending: pop and push together keep count at 15.
        for (int i = 0; i < 16; i++) begin
            in_data  = mk(600 + i);
            in_wr_en = 1'b1;
            tick();
        end
        in_wr_en = 1'b0;
        tick(); tick();
        chk("corner_count", 64'(out_count), 64'd15);
        chk("corner_full",  64'(in_full),   64'd1);
        chk("corner_head",  out_data,       mk(600));
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
        chk("corner_count_after", 64'(out_count), 64'd15);
        chk("corner_full_after",  64'(in_full),   64'd0);
        chk("corner_ovf",         64'(overflow),  64'd0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("corner_pop%0d", i), out_data, mk(600 + i));
            out_rd_en = 1'b1;
            tick();
        end
        out_rd_en = 1'b0;
        chk("corner_empty", 64'(out_empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
